// File: rtl/control_unit_pkg.sv
// Types and defaults for the pipeline stall/flush/halt controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package control_unit_pkg;

  // Stages after decode that a halt must pass through (EX, MEM, WB).
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned STALL_CNT_W_DEF  = 32;

  // Halt-drain FSM states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage : control_unit_pkg

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  // Architectural register index (32 GPRs, r0 hard-wired to zero).
  typedef logic [REG_W-1:0] regbits_t;

endpackage : cpu_types_pkg

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Hazard detection: load-use hazard between EX and decode, and MEM-stage data stall.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results feed the controller's stall/flush priority mux.
//
// Ports:
//   dren_mem_i, dwen_mem_i, dhit_i     MEM-stage data request and completion
//   dren_ex_i, regdst_ex_i             load in EX and its destination register
//   rs_de_i, rt_de_i, usert_de_i       decode-stage sources (rt only if a true source)
//   load_use_o, mem_stall_o            hazard flags
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     dren_mem_i,
  input  logic     dwen_mem_i,
  input  logic     dhit_i,
  input  logic     dren_ex_i,
  input  regbits_t regdst_ex_i,
  input  regbits_t rs_de_i,
  input  regbits_t rt_de_i,
  input  logic     usert_de_i,
  output logic     load_use_o,
  output logic     mem_stall_o
);

  logic rs_match;
  logic rt_match;

  // A pending data access that has not completed freezes the whole pipe.
  assign mem_stall_o = (dren_mem_i | dwen_mem_i) & ~dhit_i;

  // r0 is never a real dependency, so a load targeting r0 cannot hazard.
  assign rs_match   = (regdst_ex_i == rs_de_i);
  assign rt_match   = usert_de_i & (regdst_ex_i == rt_de_i);
  assign load_use_o = dren_ex_i & (regdst_ex_i != '0) & (rs_match | rt_match);

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/halt controller for the 5-stage pipeline, plus halt-drain FSM and stall counter.
// Latency: enables/flushes are combinational from state and inputs; halt and stall_cnt are registered.
// Backpressure: a MEM data miss freezes every latch; icache miss/load-use/drain hold the front end only.
//
// Ports:
//   CLK, nRST                              clock, async active-low reset
//   ihit, dhit, dREN_mem, dWEN_mem         cache status and MEM-stage request
//   dREN_ex, regDst_ex, rs_de, rt_de,
//   useRt_de                               load-use inputs
//   branch_taken_ex, halt_de               redirect from EX, halt in decode
//   pc_en, *_en, *_flush                   per-latch controls
//   halt, stall_cnt                        halted flag, saturating RUN stall count
module pipeline_ctrl
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned STALL_CNT_W  = STALL_CNT_W_DEF
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   dREN_mem,
  input  logic                   dWEN_mem,
  input  logic                   dREN_ex,
  input  regbits_t               regDst_ex,
  input  regbits_t               rs_de,
  input  regbits_t               rt_de,
  input  logic                   useRt_de,
  input  logic                   branch_taken_ex,
  input  logic                   halt_de,
  output logic                   pc_en,
  output logic                   fede_en,
  output logic                   deex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   fede_flush,
  output logic                   deex_flush,
  output logic                   exmem_flush,
  output logic                   halt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   halt_q, halt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;

  hazard_detect u_hazard_detect (
    .dren_mem_i  (dREN_mem),
    .dwen_mem_i  (dWEN_mem),
    .dhit_i      (dhit),
    .dren_ex_i   (dREN_ex),
    .regdst_ex_i (regDst_ex),
    .rs_de_i     (rs_de),
    .rt_de_i     (rt_de),
    .usert_de_i  (useRt_de),
    .load_use_o  (load_use),
    .mem_stall_o (mem_stall)
  );

  // Priority mux for latch controls. Order matters: a halted core is dead,
  // a data miss freezes everything (so a pending redirect is retried once the
  // freeze lifts), a redirect beats drain/load-use, and a same-cycle halt_de
  // in decode is squashed by the redirect's DE/EX flush.
  always_comb begin
    pc_en       = 1'b1;
    fede_en     = 1'b1;
    deex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    fede_flush  = 1'b0;
    deex_flush  = 1'b0;
    exmem_flush = 1'b0;  // held low; kept for future exception flushes

    if (state_q == HALTED) begin
      pc_en    = 1'b0;
      fede_en  = 1'b0;
      deex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      pc_en    = 1'b0;
      fede_en  = 1'b0;
      deex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (branch_taken_ex) begin
      // PC loads the redirect target even on an icache miss.
      fede_flush = 1'b1;
      deex_flush = 1'b1;
    end else if (state_q == DRAIN) begin
      pc_en      = 1'b0;
      fede_flush = 1'b1;
    end else if (load_use) begin
      // Hold the dependent instruction in decode, send a bubble into EX.
      pc_en      = 1'b0;
      fede_en    = 1'b0;
      deex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      fede_flush = 1'b1;
    end
  end

  // Halt-drain FSM. The counter tracks how many stages the halt still has to
  // pass; it only advances when MEM is not stalled, since a stall freezes the halt in place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (halt_de && !mem_stall && !branch_taken_ex && !load_use) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (cnt_q == CNT_ONE) begin
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign halt_d = (state_d == HALTED);

  // Counts RUN cycles where the PC does not advance; sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == RUN) && !pc_en && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;

endmodule : pipeline_ctrl

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall, flush and halt controller for the five-stage pipeline (fetch, decode, execute, memory, writeback). It watches cache hits, the load in execute, the decode-stage source registers, the branch resolved in execute, and the decode-stage halt. From these it drives one enable and one flush per pipeline latch plus the PC enable. It also runs the halt-drain state machine and a saturating stall-cycle counter.

## Interface
- DRAIN_CYCLES, default 3: stages after decode that halt must traverse (EX, MEM, WB).
- STALL_CNT_W, default 32: width of the stall counter.

- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access in MEM completed this cycle.
- dREN_mem, dWEN_mem  in  1 each  MEM-stage data read/write request.
- dREN_ex  in  1  instruction in EX is a load.
- regDst_ex  in  regbits_t  destination register of the EX instruction.
- rs_de, rt_de  in  regbits_t  decode-stage source registers.
- useRt_de  in  1  rt is a true source (not a destination).
- branch_taken_ex  in  1  EX redirects the PC (taken branch, jump, jr).
- halt_de  in  1  decode holds a halt instruction.
- pc_en  out  1  PC register load enable.
- fede_en, deex_en, exmem_en, memwb_en  out  1 each  latch enables.
- fede_flush, deex_flush, exmem_flush  out  1 each  load a bubble (all controls 0) on the next enabled edge.
- halt  out  1  registered; CPU halted.
- stall_cnt  out  STALL_CNT_W  cycles with pc_en=0 while in RUN, saturating.

## Operation
Conditions:
- mem_stall = (dREN_mem | dWEN_mem) & ~dhit
- load_use = dREN_ex & (regDst_ex != 0) & ((regDst_ex == rs_de) | (useRt_de & regDst_ex == rt_de))

Control outputs are combinational from state and inputs. Default: all enables 1, all flushes 0. Priority, highest first:
1. HALTED: all enables 0.
2. mem_stall: all enables 0; flushes 0. The whole pipe freezes.
3. branch_taken_ex: pc_en=1 (redirect loads even if ~ihit), fede_flush=1, deex_flush=1. Overrides load_use and squashes a same-cycle halt_de.
4. DRAIN: pc_en=0, fede_flush=1. Downstream latches advance.
5. load_use: pc_en=0, fede_en=0, deex_flush=1.
6. ~ihit: pc_en=0, fede_flush=1. Downstream latches advance.

exmem_flush is always 0; it is reserved for exception support.

Halt FSM, states RUN, DRAIN, HALTED:
- RUN→DRAIN when halt_de & ~mem_stall & ~branch_taken_ex & ~load_use. Load cnt=DRAIN_CYCLES.
- DRAIN: cnt decrements on each ~mem_stall cycle. When cnt==1 and ~mem_stall, go to HALTED.
- HALTED is terminal until nRST. halt = (state==HALTED), registered.

stall_cnt increments when state==RUN & pc_en==0 and holds at all-ones. It is not reset by halt.

## Timing
- Reset (nRST low, async): state=RUN, cnt=0, halt=0, stall_cnt=0. Enables and flushes follow the combinational rules using state RUN.
- Load-use costs exactly 1 bubble. The next cycle EX holds the bubble, so load_use drops.
- Taken branch costs 2 bubbles: the FE/DE and DE/EX contents are squashed.
- Halt decoded, leaving decode at edge t:
  - DRAIN during t+1..t+DRAIN_CYCLES (halt in EX, MEM, WB).
  - halt=1 from cycle t+DRAIN_CYCLES+1.
  - Each mem_stall cycle during DRAIN adds 1 cycle.
- mem_stall together with branch_taken_ex: the freeze wins. The redirect is taken on the first non-stalled cycle because the EX contents are held.
- nRST asserted mid-DRAIN or in HALTED: immediate return to RUN, halt=0.

## Structure
- Add `ctrl_state_t` (RUN, DRAIN, HALTED) to `control_unit_pkg`.
- `regbits_t` comes from `cpu_types_pkg`.
- One sub-module, `hazard_detect`: purely combinational. Computes load_use and mem_stall.
- FSM, drain counter, stall counter and priority mux live in `pipeline_ctrl`.

## Test plan
- Load-use: lw with regDst_ex=5 and rs_de=5, dREN_ex=1 → one cycle of pc_en=0, fede_en=0, deex_flush=1; stall_cnt +1. Same stimulus with regDst_ex=0 → no stall.
- Branch plus hazard: branch_taken_ex=1 and load_use=1 in the same cycle → pc_en=1, fede_flush=1, deex_flush=1, fede_en=1.
- Dcache miss: dREN_mem=1, dhit=0 for 4 cycles → all enables 0 for 4 cycles. dhit=1 → defaults restored.
- Icache miss: ihit=0 for 3 cycles → pc_en=0, fede_flush=1, deex_en=1; stall_cnt=3.
- Halt: halt_de at edge t with no stalls → halt=1 at t+4. Same stimulus with 2 mem_stall cycles inside DRAIN → halt=1 at t+6. halt_de with branch_taken_ex → stays in RUN.
- Reset in HALTED: nRST low for 1 cycle → halt=0 immediately, stall_cnt=0, state RUN. Also force saturation: stall_cnt at all-ones stays at all-ones.
